// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and write-back selection.
// Optional retire counter enabled by defining MEMWB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int unsigned         XLEN   = 32,
    parameter logic [XLEN-1:0]     RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            m_valid,
    input  logic [XLEN-1:0] m_pc,
    input  logic [XLEN-1:0] m_alu_res,
    input  logic [XLEN-1:0] m_mem_rdata,
    input  logic [4:0]      m_rd,
    input  logic            m_reg_we,
    input  logic [1:0]      m_wb_sel,
    input  logic [2:0]      m_ld_type,
    output logic            reg_we,
    output logic [4:0]      reg_wa,
    output logic [XLEN-1:0] reg_wd,
    output logic            wb_valid,
`ifdef MEMWB_RETIRE_CNT_EN
    output logic [XLEN-1:0] wb_pc,
    output logic [31:0]     retire_cnt
`else
    output logic [XLEN-1:0] wb_pc
`endif
);

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;
    logic [XLEN-1:0] sel_val;

    logic            valid_q, valid_d;
    logic            we_q, we_d;
    logic [4:0]      wa_q, wa_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        ld_byte = m_mem_rdata[7:0];
        case (m_alu_res[1:0])
            2'd1:    ld_byte = m_mem_rdata[15:8];
            2'd2:    ld_byte = m_mem_rdata[23:16];
            2'd3:    ld_byte = m_mem_rdata[31:24];
            default: ld_byte = m_mem_rdata[7:0];
        endcase
        // Halfword selection ignores off[0]; misaligned halves are not split.
        ld_half = m_alu_res[1] ? m_mem_rdata[31:16] : m_mem_rdata[15:0];

        ld_val = m_mem_rdata;
        case (m_ld_type)
            3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_val = m_mem_rdata;
        endcase

        sel_val = m_alu_res;
        case (m_wb_sel)
            2'b01:   sel_val = ld_val;
            2'b10:   sel_val = m_pc + XLEN'(4);
            default: sel_val = m_alu_res;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            wa_d    = '0;
            wd_d    = '0;
        end else if (!stall) begin
            valid_d = m_valid;
            we_d    = m_valid & m_reg_we & (m_rd != 5'd0);
            wa_d    = m_rd;
            wd_d    = sel_val;
            pc_d    = m_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            pc_q    <= RST_PC;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            pc_q    <= pc_d;
        end
    end

`ifdef MEMWB_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts instructions entering WB; stalled and flushed cycles are excluded.
    always_comb begin
        cnt_d = cnt_q;
        if (!flush && !stall && m_valid) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`endif

    assign reg_we   = we_q;
    assign reg_wa   = wa_q;
    assign reg_wd   = wd_q;
    assign wb_valid = valid_q;
    assign wb_pc    = pc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the WB register.
module tb_mem_wb_stage;

    localparam logic [31:0] RstPc = 32'hDEAD_BEE0;

    logic        clk = 1'b0;
    logic        rst, stall, flush, m_valid, m_reg_we;
    logic [31:0] m_pc, m_alu_res, m_mem_rdata;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_ld_type;
    logic        reg_we, wb_valid;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd, wb_pc;
`ifdef MEMWB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int passes = 0;

    // Model state
    logic        e_we, e_valid;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_pc, e_cnt;

    mem_wb_stage #(.XLEN(32), .RST_PC(RstPc)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_pc        (m_pc),
        .m_alu_res   (m_alu_res),
        .m_mem_rdata (m_mem_rdata),
        .m_rd        (m_rd),
        .m_reg_we    (m_reg_we),
        .m_wb_sel    (m_wb_sel),
        .m_ld_type   (m_ld_type),
        .reg_we      (reg_we),
        .reg_wa      (reg_wa),
        .reg_wd      (reg_wd),
        .wb_valid    (wb_valid),
`ifdef MEMWB_RETIRE_CNT_EN
        .wb_pc       (wb_pc),
        .retire_cnt  (retire_cnt)
`else
        .wb_pc       (wb_pc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_wd(input logic [1:0] sel, input logic [31:0] pc,
                                           input logic [31:0] alu, input logic [31:0] rdata,
                                           input logic [2:0] ld);
        logic [31:0] v;
        int          off;
        off = int'(alu[1:0]);
        if (sel == 2'b10) return pc + 32'd4;
        if (sel != 2'b01) return alu;
        if (ld == 3'd0 || ld == 3'd4) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (ld == 3'd0 && v >= 32'h80) v = v - 32'h100;
        end else if (ld == 3'd1 || ld == 3'd5) begin
            v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            if (ld == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic we,
                         input logic [1:0] sel, input logic [2:0] ld);
        m_valid = v; m_pc = pc; m_alu_res = alu; m_mem_rdata = rdata;
        m_rd = rd; m_reg_we = we; m_wb_sel = sel; m_ld_type = ld;
    endtask

    // Advance one edge and update the model from the inputs seen at that edge.
    task automatic tick();
        logic        n_we, n_valid;
        logic [4:0]  n_wa;
        logic [31:0] n_wd, n_pc, n_cnt;
        n_we = e_we; n_valid = e_valid; n_wa = e_wa; n_wd = e_wd; n_pc = e_pc; n_cnt = e_cnt;
        if (rst) begin
            n_we = 0; n_valid = 0; n_wa = 0; n_wd = 0; n_pc = RstPc; n_cnt = 0;
        end else if (flush) begin
            n_we = 0; n_valid = 0; n_wa = 0; n_wd = 0;
        end else if (!stall) begin
            n_valid = m_valid;
            n_we    = m_valid && m_reg_we && m_rd != 0;
            n_wa    = m_rd;
            n_wd    = ref_wd(m_wb_sel, m_pc, m_alu_res, m_mem_rdata, m_ld_type);
            n_pc    = m_pc;
            if (m_valid) n_cnt = e_cnt + 1;
        end
        @(posedge clk);
        #1;
        e_we = n_we; e_valid = n_valid; e_wa = n_wa; e_wd = n_wd; e_pc = n_pc; e_cnt = n_cnt;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0;
        drive(1, 32'h100, 32'h55, 32'h0, 5'd3, 1, 2'b00, 3'd2);
        tick();
        rst = 0;
        checks++;
        if ({reg_we, reg_wa, reg_wd, wb_valid, wb_pc} !== {1'b0, 5'd0, 32'd0, 1'b0, RstPc})
            $display("FAIL reset_state: got we=%b wa=%0d wd=%h v=%b pc=%h, want 0/0/0/0/%h",
                     reg_we, reg_wa, reg_wd, wb_valid, wb_pc, RstPc);
        else passes++;
    endtask

    task automatic test_alu_write();
        drive(1, 32'h200, 32'h1234_5678, 32'h0, 5'd5, 1, 2'b00, 3'd0);
        tick();
        checks++;
        if ({reg_we, reg_wa, reg_wd, wb_valid, wb_pc} !== {1'b1, 5'd5, 32'h1234_5678, 1'b1, 32'h200})
            $display("FAIL alu_write: got we=%b wa=%0d wd=%h v=%b pc=%h, want 1/5/12345678/1/200",
                     reg_we, reg_wa, reg_wd, wb_valid, wb_pc);
        else passes++;
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [1:0]  off [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3};
        logic [31:0] exp [6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                                 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h300, {30'h400, off[i]}, 32'h80FF_7F01, 5'd9, 1, 2'b01, lt[i]);
            tick();
            checks++;
            if (reg_wd !== exp[i] || reg_we !== 1'b1)
                $display("FAIL load_%0d: got wd=%h we=%b, want wd=%h we=1", i, reg_wd, reg_we, exp[i]);
            else passes++;
        end
    endtask

    task automatic test_x0_pc4();
        drive(1, 32'h400, 32'hABCD, 32'h0, 5'd0, 1, 2'b00, 3'd0);
        tick();
        checks++;
        if (reg_we !== 1'b0 || wb_valid !== 1'b1)
            $display("FAIL x0_write: got we=%b v=%b, want we=0 v=1", reg_we, wb_valid);
        else passes++;
        drive(1, 32'hFFFF_FFFC, 32'h1111, 32'h0, 5'd1, 1, 2'b10, 3'd0);
        tick();
        checks++;
        if (reg_wd !== 32'h0 || reg_we !== 1'b1 || reg_wa !== 5'd1)
            $display("FAIL pc4_wrap: got wd=%h we=%b wa=%0d, want 0/1/1", reg_wd, reg_we, reg_wa);
        else passes++;
    endtask

    task automatic test_stall_flush();
        drive(1, 32'h500, 32'hAAAA_5555, 32'h0, 5'd7, 1, 2'b00, 3'd0);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, $urandom, $urandom, 5'd12, 1, 2'b00, 3'd0);
            tick();
            checks++;
            if ({reg_we, reg_wa, reg_wd, wb_valid, wb_pc} !== {1'b1, 5'd7, 32'hAAAA_5555, 1'b1, 32'h500})
                $display("FAIL stall_hold_%0d: got we=%b wa=%0d wd=%h pc=%h, want 1/7/aaaa5555/500",
                         i, reg_we, reg_wa, reg_wd, wb_pc);
            else passes++;
        end
        flush = 1;
        tick();
        checks++;
        if ({reg_we, reg_wa, reg_wd, wb_valid, wb_pc} !== {1'b0, 5'd0, 32'd0, 1'b0, 32'h500})
            $display("FAIL stall_flush: got we=%b wa=%0d wd=%h v=%b pc=%h, want 0/0/0/0/500",
                     reg_we, reg_wa, reg_wd, wb_valid, wb_pc);
        else passes++;
        stall = 0; flush = 0;
    endtask

    task automatic test_midstream_reset();
        drive(1, 32'h600, 32'h77, 32'h0, 5'd4, 1, 2'b00, 3'd0);
        tick();
        rst = 1; stall = 1;
        drive(1, 32'h604, 32'h88, 32'h0, 5'd6, 1, 2'b00, 3'd0);
        tick();
        rst = 0; stall = 0;
        checks++;
        if ({reg_we, reg_wa, reg_wd, wb_valid, wb_pc} !== {1'b0, 5'd0, 32'd0, 1'b0, RstPc})
            $display("FAIL midstream_reset: got we=%b wa=%0d wd=%h v=%b pc=%h, want 0/0/0/0/%h",
                     reg_we, reg_wa, reg_wd, wb_valid, wb_pc, RstPc);
        else passes++;
        drive(1, 32'h608, 32'h99, 32'h0, 5'd8, 1, 2'b00, 3'd0);
        tick();
        checks++;
        if ({reg_we, reg_wa, reg_wd, wb_valid} !== {1'b1, 5'd8, 32'h99, 1'b1})
            $display("FAIL first_after_reset: got we=%b wa=%0d wd=%h v=%b, want 1/8/99/1",
                     reg_we, reg_wa, reg_wd, wb_valid);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom), 3'($urandom));
            tick();
            checks++;
            if ({reg_we, reg_wa, reg_wd, wb_valid, wb_pc} !== {e_we, e_wa, e_wd, e_valid, e_pc})
                $display("FAIL random_%0d: got we=%b wa=%0d wd=%h v=%b pc=%h, want %b/%0d/%h/%b/%h",
                         i, reg_we, reg_wa, reg_wd, wb_valid, wb_pc, e_we, e_wa, e_wd, e_valid, e_pc);
            else passes++;
`ifdef MEMWB_RETIRE_CNT_EN
            checks++;
            if (retire_cnt !== e_cnt)
                $display("FAIL random_cnt_%0d: got %0d, want %0d", i, retire_cnt, e_cnt);
            else passes++;
`endif
        end
        rst = 0; stall = 0; flush = 0;
    endtask

`ifdef MEMWB_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        rst = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
        tick();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 32'(i), 0, 5'd2, 1, 2'b00, 3'd0);
            if (i % 3 == 0 && i < 9) begin
                stall = 1; tick(); tick(); stall = 0;
            end
            if (i == 4 || i == 7) begin
                flush = 1; tick(); flush = 0;
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
        tick();
        checks++;
        if (retire_cnt !== 32'd10)
            $display("FAIL retire_cnt: got %0d, want 10", retire_cnt);
        else passes++;
    endtask
`endif

    initial begin
        e_we = 0; e_valid = 0; e_wa = 0; e_wd = 0; e_pc = RstPc; e_cnt = 0;
        test_reset();
        test_alu_write();
        test_loads();
        test_x0_pc4();
        test_stall_flush();
        test_midstream_reset();
`ifdef MEMWB_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
